// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-wide UART transmitter among NREQ requesters.
// Define UART_ARB_TAG_EN to prefix a requester-id tag byte whenever the grant changes hands.
module uart_tx_arbiter #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned IDW         = 2,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [NREQ-1:0]   i_req_valid,
    input  logic [8*NREQ-1:0] i_req_data,
    output logic [NREQ-1:0]   o_req_ready,
    output logic              o_tx_wr,
    output logic [7:0]        o_tx_data,
    input  logic              i_tx_busy,
    output logic [IDW-1:0]    o_grant_id,
    output logic              o_active,
    output logic              o_timeout
);

    localparam int unsigned CNTW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   ready_q, ready_d;
    logic              tx_wr_q, tx_wr_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [IDW-1:0]    grant_q, grant_d;
    logic              active_q, active_d;
    logic              timeout_q, timeout_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;

`ifdef UART_ARB_TAG_EN
    logic              pend_q, pend_d;
    logic [7:0]        hold_q, hold_d;
    logic              first_q, first_d;
`endif

    logic              pick_found_c;
    logic [IDW-1:0]    pick_idx_c;
    logic [7:0]        pick_data_c;
    int unsigned       pick_dist_c;

    // Distance 0 is the requester right after the last grant; the last grant itself is farthest.
    always_comb begin
        pick_found_c = 1'b0;
        pick_idx_c   = '0;
        pick_data_c  = '0;
        pick_dist_c  = NREQ;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (i_req_valid[j] &&
                (((j + NREQ - 1 - 32'(grant_q)) % NREQ) < pick_dist_c)) begin
                pick_found_c = 1'b1;
                pick_idx_c   = IDW'(j);
                pick_data_c  = i_req_data[8*j +: 8];
                pick_dist_c  = (j + NREQ - 1 - 32'(grant_q)) % NREQ;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ready_d   = '0;
        tx_wr_d   = tx_wr_q;
        tx_data_d = tx_data_q;
        grant_d   = grant_q;
        active_d  = active_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
`ifdef UART_ARB_TAG_EN
        pend_d    = pend_q;
        hold_d    = hold_q;
        first_d   = first_q;
`endif
        case (state_q)
            IDLE: begin
                tx_wr_d = 1'b0;
                if (!i_tx_busy && pick_found_c) begin
                    ready_d   = NREQ'(1) << pick_idx_c;
                    tx_data_d = pick_data_c;
                    grant_d   = pick_idx_c;
                    active_d  = 1'b1;
                    state_d   = ISSUE;
`ifdef UART_ARB_TAG_EN
                    first_d = 1'b0;
                    if (first_q || (pick_idx_c != grant_q)) begin
                        tx_data_d = {4'hA, 1'b0, 3'(pick_idx_c)};
                        hold_d    = pick_data_c;
                        pend_d    = 1'b1;
                    end
`endif
                end
            end
            ISSUE: begin
                tx_wr_d = 1'b1;
                cnt_d   = '0;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (i_tx_busy) begin
                    tx_wr_d = 1'b0;
                    state_d = WAIT_LO;
                end else if (cnt_q == CNTW'(ACK_TIMEOUT - 1)) begin
                    // Transmitter never acknowledged: drop the byte (and any pending data byte).
                    tx_wr_d   = 1'b0;
                    timeout_d = 1'b1;
                    active_d  = 1'b0;
                    state_d   = IDLE;
`ifdef UART_ARB_TAG_EN
                    pend_d    = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            WAIT_LO: begin
                if (!i_tx_busy) begin
                    active_d = 1'b0;
                    state_d  = IDLE;
`ifdef UART_ARB_TAG_EN
                    if (pend_q) begin
                        active_d  = 1'b1;
                        tx_data_d = hold_q;
                        pend_d    = 1'b0;
                        state_d   = ISSUE;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            ready_q   <= '0;
            tx_wr_q   <= 1'b0;
            tx_data_q <= 8'h00;
            grant_q   <= IDW'(NREQ - 1);
            active_q  <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            tx_wr_q   <= tx_wr_d;
            tx_data_q <= tx_data_d;
            grant_q   <= grant_d;
            active_q  <= active_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef UART_ARB_TAG_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pend_q  <= 1'b0;
            hold_q  <= 8'h00;
            first_q <= 1'b1;
        end else begin
            pend_q  <= pend_d;
            hold_q  <= hold_d;
            first_q <= first_d;
        end
    end
`endif

    assign o_req_ready = ready_q;
    assign o_tx_wr     = tx_wr_q;
    assign o_tx_data   = tx_data_q;
    assign o_grant_id  = grant_q;
    assign o_active    = active_q;
    assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter with a behavioural UART transmitter model.
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ        = 4;
    localparam int unsigned IDW         = 2;
    localparam int unsigned ACK_TIMEOUT = 16;

    logic              i_clk       = 1'b0;
    logic              i_reset     = 1'b1;
    logic [NREQ-1:0]   i_req_valid = '0;
    logic [8*NREQ-1:0] i_req_data  = '0;
    logic              i_tx_busy   = 1'b0;
    logic [NREQ-1:0]   o_req_ready;
    logic              o_tx_wr;
    logic [7:0]        o_tx_data;
    logic [IDW-1:0]    o_grant_id;
    logic              o_active;
    logic              o_timeout;

    uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_req_valid(i_req_valid), .i_req_data(i_req_data),
        .o_req_ready(o_req_ready), .o_tx_wr(o_tx_wr), .o_tx_data(o_tx_data), .i_tx_busy(i_tx_busy),
        .o_grant_id(o_grant_id), .o_active(o_active), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [7:0] exp_q[$];
    int         grant_log[$];
    int         n_pushed = 0, n_dropped = 0, frames_seen = 0;

    // Transmitter model: samples a write, raises busy after a latency, stays busy for a frame.
    int ack_lat = 1, frame_len = 4, lat_cnt = 0, fr_cnt = 0;
    bit noack = 0, rand_tx = 0, tx_pend = 0;

    always @(posedge i_clk) begin
        if (fr_cnt > 0) begin
            fr_cnt--;
            if (fr_cnt == 0) i_tx_busy <= 1'b0;
        end else if (tx_pend) begin
            if (lat_cnt <= 1) begin
                tx_pend = 0;
                i_tx_busy <= 1'b1;
                fr_cnt = rand_tx ? int'($urandom_range(2, 8)) : frame_len;
            end else begin
                lat_cnt--;
            end
        end else if (o_tx_wr && !i_tx_busy && !noack) begin
            tx_pend = 1;
            lat_cnt = rand_tx ? int'($urandom_range(1, 3)) : ack_lat;
            frames_seen++;
            if (exp_q.size() == 0) check("sb_underflow", int'(exp_q.size()), 1);
            else                   check("frame_data", int'(o_tx_data), int'(exp_q.pop_front()));
        end
    end

    // Round-robin reference: first valid requester after the last granted one, with wrap.
    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= int'(NREQ); k++) begin
            int idx;
            idx = (last + k) % int'(NREQ);
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Requesters plus scoreboard producer; valid/data of a readied requester held through the handshake edge.
    int unsigned rem[NREQ];
    logic [7:0]  dat[NREQ];
    int          acc_cnt[NREQ];
    bit          rnd_mode = 0, first_grant = 1;
    int          last_grant = NREQ - 1, pend_acc = -1;

    always @(negedge i_clk) begin
        if (i_reset) begin
            last_grant  = NREQ - 1;
            first_grant = 1;
            n_dropped  += exp_q.size();
            exp_q.delete();
            pend_acc    = -1;
        end else begin
            if (pend_acc >= 0) begin
                if (rem[pend_acc] > 0) rem[pend_acc]--;
                if (rnd_mode) dat[pend_acc] = 8'($urandom);
                pend_acc = -1;
            end
            if (o_req_ready != '0) begin
                int w;
                w = rr_pick(i_req_valid, last_grant);
                check("ready_onehot", $countones(o_req_ready), 1);
                check("ready_winner", int'(o_req_ready), (w < 0) ? 0 : (1 << w));
                if (w >= 0) begin
                    check("grant_id", int'(o_grant_id), w);
                    acc_cnt[w]++;
                    grant_log.push_back(w);
                    if (!noack) begin
`ifdef UART_ARB_TAG_EN
                        if (first_grant || w != last_grant) begin
                            exp_q.push_back({4'hA, 1'b0, 3'(w)});
                            n_pushed++;
                        end
`endif
                        exp_q.push_back(i_req_data[8*w +: 8]);
                        n_pushed++;
                    end
                    first_grant = 0;
                    last_grant  = w;
                    pend_acc    = w;
                end
            end
        end
        for (int k = 0; k < int'(NREQ); k++) begin
            if (k != pend_acc) begin
                i_req_valid[k] = rnd_mode ? ($urandom_range(0, 3) != 0) : (rem[k] > 0);
                i_req_data[8*k +: 8] = dat[k];
            end
        end
    end

    task automatic wait_idle(input string name);
        int n;
        bit done;
        n = 0;
        done = 0;
        while (!done && n < 3000) begin
            @(negedge i_clk);
            n++;
            done = !o_active && !i_tx_busy && (exp_q.size() == 0) && !rnd_mode && (pend_acc < 0);
            for (int k = 0; k < int'(NREQ); k++) if (rem[k] != 0) done = 0;
        end
        check(name, int'(done), 1);
    endtask

    task automatic pulse_reset();
        @(posedge i_clk); #1 i_reset = 1'b1;
        @(posedge i_clk); #1 i_reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int log0, wr_cnt, to_cnt, cnt_busy_ready, n;
        int snap[NREQ];
        bit seen_act;
        logic [7:0] t1_exp;
        for (int k = 0; k < int'(NREQ); k++) begin
            rem[k] = 0; dat[k] = 8'h00; acc_cnt[k] = 0;
        end
        i_reset = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_ready",   int'(o_req_ready), 0);
        check("rst_tx_wr",   int'(o_tx_wr), 0);
        check("rst_tx_data", int'(o_tx_data), 0);
        check("rst_grant",   int'(o_grant_id), NREQ - 1);
        check("rst_active",  int'(o_active), 0);
        check("rst_timeout", int'(o_timeout), 0);

        // Single byte: ready then write two cycles after valid.
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        ack_lat = 3; frame_len = 6; dat[0] = 8'h56; rem[0] = 1;
`ifdef UART_ARB_TAG_EN
        t1_exp = 8'hA0;
`else
        t1_exp = 8'h56;
`endif
        @(negedge i_clk);
        @(negedge i_clk);
        check("t1_ready", int'(o_req_ready), 1);
        check("t1_wr_early", int'(o_tx_wr), 0);
        @(negedge i_clk);
        check("t1_wr_latency", int'(o_tx_wr), 1);
        check("t1_data", int'(o_tx_data), int'(t1_exp));
        wait_idle("t1_drain");
        check("t1_accepts", acc_cnt[0], 1);

        // All requesters held valid: strict rotation from requester 0.
        pulse_reset();
        ack_lat = 1; frame_len = 4;
        log0 = grant_log.size();
        for (int k = 0; k < int'(NREQ); k++) begin dat[k] = 8'h10 + 8'(k); rem[k] = 5; end
        wait_idle("t2_drain");
        for (int i = 0; i < 5; i++) begin
            if (grant_log.size() > log0 + i) check("t2_rotation", grant_log[log0 + i], i % int'(NREQ));
            else                             check("t2_log_len", grant_log.size(), log0 + i + 1);
        end

        // Single requester granted repeatedly, nobody else readied.
        for (int k = 0; k < int'(NREQ); k++) snap[k] = acc_cnt[k];
        dat[2] = 8'h77; rem[2] = 3;
        wait_idle("t3_drain");
        for (int k = 0; k < int'(NREQ); k++) check("t3_accepts", acc_cnt[k] - snap[k], (k == 2) ? 3 : 0);

        // Transmitter never acknowledges: write held ACK_TIMEOUT cycles, single timeout pulse.
        noack = 1; dat[1] = 8'h5A; rem[1] = 1;
        wr_cnt = 0; to_cnt = 0; seen_act = 0; n = 0;
        while (n < 100 && !(seen_act && !o_active)) begin
            @(negedge i_clk);
            n++;
            if (o_tx_wr) wr_cnt++;
            if (o_timeout) to_cnt++;
            if (o_active) seen_act = 1;
        end
        check("t4_wr_cycles", wr_cnt, ACK_TIMEOUT);
        check("t4_timeout_pulses", to_cnt, 1);
        @(negedge i_clk);
        check("t4_timeout_width", int'(o_timeout), 0);
        noack = 0;
        dat[2] = 8'hC3; rem[2] = 1;
        wait_idle("t4_recover");

        // Reset while the transmitter is mid-frame.
        frame_len = 12; dat[1] = 8'h99; rem[1] = 1;
        n = 0;
        while (n < 100 && !(i_tx_busy && o_active && !o_tx_wr)) begin
            @(negedge i_clk);
            n++;
        end
        check("t5_reached_wait_lo", int'(i_tx_busy && o_active && !o_tx_wr), 1);
        @(posedge i_clk); #1 i_reset = 1'b1;
        @(posedge i_clk); #1 i_reset = 1'b0;
        check("t5_wr_after_reset", int'(o_tx_wr), 0);
        check("t5_grant_after_reset", int'(o_grant_id), NREQ - 1);
        check("t5_active_after_reset", int'(o_active), 0);
        log0 = grant_log.size();
        for (int k = 0; k < int'(NREQ); k++) begin dat[k] = 8'h40 + 8'(k); rem[k] = 1; end
        cnt_busy_ready = 0; n = 0;
        while (n < 100 && i_tx_busy) begin
            @(negedge i_clk);
            n++;
            if (i_tx_busy && o_req_ready != '0) cnt_busy_ready++;
        end
        check("t5_no_grant_while_busy", cnt_busy_ready, 0);
        frame_len = 4;
        wait_idle("t5_drain");
        if (grant_log.size() > log0) check("t5_first_grant", grant_log[log0], 0);
        else                         check("t5_log_len", grant_log.size(), log0 + 1);

`ifdef UART_ARB_TAG_EN
        // Tag bytes when the grant changes hands.
        pulse_reset();
        dat[1] = 8'h31; rem[1] = 2;
        wait_idle("tag_req1");
        dat[3] = 8'h33; rem[3] = 1;
        wait_idle("tag_req3");
`endif

        // Randomized traffic against the reference model.
        rand_tx = 1;
        for (int k = 0; k < int'(NREQ); k++) dat[k] = 8'($urandom);
        rnd_mode = 1;
        repeat (1500) @(negedge i_clk);
        rnd_mode = 0;
        wait_idle("rand_drain");
        check("frames_total", frames_seen, n_pushed - n_dropped);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single 8-bit UART transmitter (i_wr / i_data / o_busy / o_uart_tx interface) between NREQ byte-producing requesters. Round-robin arbitration, one byte per grant. Captures the granted byte, drives the transmitter's write strobe and tracks its busy flag until the frame is finished. Sits between SoC peripherals (debug console, CPU MMIO port, etc.) and the tx instance.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, requester index width, must be >= clog2(NREQ)
ACK_TIMEOUT, 16, max cycles to wait for i_tx_busy to rise after o_tx_wr asserts

Ports:
i_clk  input  1  system clock
i_reset  input  1  synchronous active-high reset
i_req_valid  input  NREQ  per-requester byte-valid
i_req_data  input  8*NREQ  per-requester byte, requester k on bits [8k+7:8k]
o_req_ready  output  NREQ  one-cycle accept pulse, at most one bit set
o_tx_wr  output  1  write strobe to transmitter i_wr
o_tx_data  output  8  byte to transmitter i_data
i_tx_busy  input  1  transmitter o_busy
o_grant_id  output  IDW  index of requester last granted
o_active  output  1  high from byte accept until transmitter returns idle
o_timeout  output  1  one-cycle pulse, busy never rose within ACK_TIMEOUT

Behaviour:
- Clock i_clk; i_reset synchronous, active-high. All outputs registered.
- Reset values: o_req_ready=0, o_tx_wr=0, o_tx_data=8'h00, o_grant_id=NREQ-1, o_active=0, o_timeout=0, state IDLE, timeout counter 0.
- States: IDLE, ISSUE, WAIT_HI, WAIT_LO.
- IDLE: if i_tx_busy=0 and any i_req_valid set, pick first set bit searching from (o_grant_id+1) mod NREQ upward with wrap; same cycle pulse that o_req_ready bit, latch byte into o_tx_data, update o_grant_id, o_active=1, go ISSUE. If i_tx_busy=1 (e.g. frame still shifting after reset), stay IDLE.
- Requester handshake: byte transferred on clock edge where i_req_valid[k] & o_req_ready[k]. Requester may hold valid across cycles; ready never asserts while not IDLE, so back-to-back grants separated by >= one full frame.
- ISSUE: o_tx_wr=1, o_tx_data stable; go WAIT_HI. Latency valid->o_tx_wr = 2 cycles.
- WAIT_HI: hold o_tx_wr=1 until i_tx_busy=1, then o_tx_wr=0, go WAIT_LO. Counter increments each cycle; at ACK_TIMEOUT without busy: o_tx_wr=0, o_timeout pulse, o_active=0, go IDLE (byte dropped).
- WAIT_LO: wait i_tx_busy=0, then o_active=0, go IDLE. Next grant earliest the following cycle.
- Round-robin: last-granted requester lowest priority; single requester may be granted repeatedly.
- Simultaneous valid on all: grant order strictly rotates.
- Requester dropping valid before accept: no effect, not granted.
- Reset mid-frame: state forced IDLE, o_tx_wr=0 next edge; transmitter finishes frame; arbiter waits for i_tx_busy=0 before next grant.
- o_tx_data not modified outside the accept cycle.

Optional Feature:
Macro UART_ARB_TAG_EN. Defined: when a newly granted requester differs from the previous grant (or first grant after reset), arbiter first sends tag byte {4'hA, 1'b0, id zero-extended to 3 bits}, full ISSUE/WAIT_HI/WAIT_LO sequence, then sends the data byte without re-arbitrating; o_active stays high across both frames; timeout on tag frame drops both bytes. Undefined: no tag bytes, data bytes only.

Test Plan:
- Reset then valid[0]=1, data 8'h56, tx model busy 3 cycles after wr -> ready[0] pulses once, o_tx_wr rises 2 cycles after valid, data 8'h56, o_active low after busy falls.
- valid=4'b1111 held, bytes 8'h10..8'h13 -> serial order 10,11,12,13,10..., o_grant_id 0,1,2,3,0.
- Only valid[2] held, 3 bytes -> three frames from requester 2, no ready on others, no overlap of o_tx_wr with busy.
- Tx model never raises busy -> o_tx_wr high exactly 16 cycles, o_timeout one pulse, back to IDLE, next request served.
- i_reset asserted in WAIT_LO while busy=1 -> o_tx_wr=0, no grant until busy falls, grant_id returns to NREQ-1 so requester 0 served first.
- UART_ARB_TAG_EN: requester 1 then 1 then 3 -> frames 8'hA1,d,d,8'hA3,d.
